// File: rtl/axi_packet_framer.sv
// Frames raw multi-lane sample beats with tfirst/tlast according to a runtime frame length,
// buffers them in a small FIFO and drives them onto an axi_packet master interface.
module axi_packet_framer #(
   parameter int DATA_WIDTH = 16,
   parameter int LANE       = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANE*DATA_WIDTH-1:0]   in_bus,
   input  logic [LEN_WIDTH-1:0]         frame_len,
   output logic                         tvalid,
   input  logic                         tready,
   output logic signed [DATA_WIDTH-1:0] bus [LANE],
   output logic                         tfirst,
   output logic                         tlast,
   output logic [15:0]                  frames_sent
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = LANE*DATA_WIDTH + 2;   // {tfirst, tlast, lanes}

   localparam logic [AW:0]          PTR_ONE = 1;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

   logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
   logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, eff_len;
   logic [EW-1:0]        head_q, head_d, push_entry;
   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [15:0]          frames_q, frames_d;
   logic                 open_q;
   logic                 empty, full, push, pop;
   logic                 first_beat, last_beat;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

   assign in_ready = open_q & ~full;
   assign push     = in_valid & in_ready;
   assign tvalid   = ~empty;
   assign pop      = tvalid & tready;

   // The frame length is captured only on the first beat; later beats use len_q.
   always_comb begin
      first_beat = (cnt_q == '0);
      eff_len    = len_q;
      if (first_beat) begin
         eff_len = (frame_len == '0) ? LEN_ONE : frame_len;
      end
      last_beat  = (cnt_q == eff_len - LEN_ONE);
      push_entry = {first_beat, last_beat, in_bus};
      cnt_d      = cnt_q;
      len_d      = len_q;
      if (push) begin
         len_d = eff_len;
         cnt_d = last_beat ? '0 : cnt_q + LEN_ONE;
      end
   end

   always_comb begin
      wr_d     = wr_q + (push ? PTR_ONE : '0);
      rd_d     = rd_q + (pop  ? PTR_ONE : '0);
      frames_d = frames_q + ((pop && tlast) ? 16'd1 : 16'd0);
   end

   // Head register holds the entry that will be at rd_d after this edge; when the
   // FIFO drains it keeps its last value.
   always_comb begin
      head_d = head_q;
      if (push && (rd_d == wr_q)) begin
         head_d = push_entry;
      end else if (rd_d != wr_d) begin
         head_d = mem_q[rd_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         len_q    <= LEN_ONE;
         head_q   <= '0;
         frames_q <= '0;
         open_q   <= 1'b0;
      end else begin
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         head_q   <= head_d;
         frames_q <= frames_d;
         open_q   <= 1'b1;
      end
   end

   // NOTE: storage array is deliberately not reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q[AW-1:0]] <= push_entry;
      end
   end

   assign tfirst      = head_q[EW-1];
   assign tlast       = head_q[EW-2];
   assign frames_sent = frames_q;

   for (genvar k = 0; k < LANE; k++) begin : g_lane
      assign bus[k] = head_q[k*DATA_WIDTH +: DATA_WIDTH];
   end

endmodule
